// File: rtl/usi_master_seq_pkg.sv
// Shared definitions for the USI master command sequencer.
//   - USI command encodings carried in bus address bits [31:30]
//   - bus addresses of the slaves on the USI bus
//   - error data word returned on a failed request
//   - width of the slave-ready timeout counter
//   - sequencer FSM state type
//   - helper that packs a bus command word
package usi_master_seq_pkg;

    localparam logic [1:0] USI_CMD_IDLE = 2'b00;
    localparam logic [1:0] USI_CMD_WR   = 2'b01;
    localparam logic [1:0] USI_CMD_RD   = 2'b10;

    localparam logic [7:0] USI_ADRS_GPIO  = 8'h01;
    localparam logic [7:0] USI_ADRS_UART  = 8'h02;
    localparam logic [7:0] USI_ADRS_SPI   = 8'h03;
    localparam logic [7:0] USI_ADRS_I2C   = 8'h04;
    localparam logic [7:0] USI_ADRS_TIMER = 8'h05;
    localparam logic [7:0] USI_ADRS_PWM   = 8'h06;
    localparam logic [7:0] USI_ADRS_ADC   = 8'h07;
    localparam logic [7:0] USI_ADRS_FLASH = 8'h08;
    localparam logic [7:0] USI_ADRS_PSRAM = 8'h09;

    localparam logic [31:0] USI_ERR_DATA = 32'hDEAD_BEEF;

    localparam int USI_TMR_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_VD = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RESP    = 3'd4
    } usi_state_e;

    // Bus command word: {cmd, 6'b0, bus address, CSR address}.
    function automatic logic [31:0] usi_mk_adrs(input logic [1:0]  cmd,
                                                input logic [7:0]  bus_adrs,
                                                input logic [15:0] csr_adrs);
        return {cmd, 6'b0, bus_adrs, csr_adrs};
    endfunction

endpackage

// File: rtl/usi_master_seq_if.sv
// Signal bundle between the CPU-side requester, the USI master sequencer
// and the USI bus block.
//   Request : iReqVd/oReqRdy handshake, iReqWr, iReqBusAdrs[7:0],
//             iReqCsrAdrs[15:0], iReqWd[31:0]
//   Response: oRspVd pulse, oRspRd[31:0], oRspErr
//   Bus     : oMUsiWd[31:0], oMUsiAdrs[31:0], oMUsiWCke (to bus),
//             iMUsiRd[31:0], iMUsiVd[pBusNum-1:0] (from bus)
// modport master: the sequencer's view; modport slave: the environment's view.
interface usi_master_seq_if #(
    parameter int pBusNum = 1
) ();

    logic                iReqVd;
    logic                oReqRdy;
    logic                iReqWr;
    logic [7:0]          iReqBusAdrs;
    logic [15:0]         iReqCsrAdrs;
    logic [31:0]         iReqWd;
    logic                oRspVd;
    logic [31:0]         oRspRd;
    logic                oRspErr;
    logic [31:0]         oMUsiWd;
    logic [31:0]         oMUsiAdrs;
    logic                oMUsiWCke;
    logic [31:0]         iMUsiRd;
    logic [pBusNum-1:0]  iMUsiVd;

    modport master (
        input  iReqVd, iReqWr, iReqBusAdrs, iReqCsrAdrs, iReqWd, iMUsiRd, iMUsiVd,
        output oReqRdy, oRspVd, oRspRd, oRspErr, oMUsiWd, oMUsiAdrs, oMUsiWCke
    );

    modport slave (
        output iReqVd, iReqWr, iReqBusAdrs, iReqCsrAdrs, iReqWd, iMUsiRd, iMUsiVd,
        input  oReqRdy, oRspVd, oRspRd, oRspErr, oMUsiWd, oMUsiAdrs, oMUsiWCke
    );

endinterface

// File: rtl/usi_master_seq_vd_timer.sv
// Slave-ready watcher for the USI master sequencer.
// Selects the Vd bit of the addressed slave (bus address n -> bit n-1) and
// counts cycles spent waiting for it.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : restart the wait counter from 0
//   en_i          : sequencer is waiting for the slave
//   bus_adrs_i    : latched target bus address
//   vd_i          : per-slave ready bits from the bus
//   hit_o         : addressed slave is ready this cycle
//   timeout_o     : waited pTimeout cycles and the slave is still not ready
module usi_master_seq_vd_timer
    import usi_master_seq_pkg::*;
#(
    parameter int pBusNum  = 1,
    parameter int pTimeout = 1023
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [7:0]         bus_adrs_i,
    input  logic [pBusNum-1:0] vd_i,
    output logic               hit_o,
    output logic               timeout_o
);

    localparam logic [USI_TMR_W-1:0] LIMIT = USI_TMR_W'(pTimeout);

    logic [USI_TMR_W-1:0] cnt_q, cnt_d;

    // Compare against every legal address so an out-of-range address can
    // never index past the Vd vector; it simply never hits.
    always_comb begin
        hit_o = 1'b0;
        for (int i = 0; i < pBusNum; i++) begin
            if (bus_adrs_i == 8'(i + 1) && vd_i[i]) begin
                hit_o = 1'b1;
            end
        end
    end

    assign timeout_o = en_i && !hit_o && (cnt_q == LIMIT);

    // Saturates at the limit instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !hit_o && cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/usi_master_seq.sv
// USI master command sequencer.
// Takes one CPU request at a time, waits for the addressed slave's Vd bit,
// issues a single write or read command on the USI master write port and
// returns write completion, read data or an error as a one-cycle pulse.
//   iUsiClk : bus clock
//   iUsiRst : asynchronous reset, active-low
//   bus     : usi_master_seq_if.master (request, response and bus signals)
// Parameters: pBusNum slaves (1..16), pRdLat read latency in cycles (>=1),
// pTimeout maximum cycles to wait for slave Vd (<=1023).
// Every output comes straight from a register.
module usi_master_seq
    import usi_master_seq_pkg::*;
#(
    parameter int pBusNum  = 1,
    parameter int pRdLat   = 3,
    parameter int pTimeout = 1023
) (
    input  logic             iUsiClk,
    input  logic             iUsiRst,
    usi_master_seq_if.master bus
);

    localparam int         pBusWidth = pBusNum - 1;
    localparam logic [7:0] RD_LAST   = 8'(pRdLat);

    usi_state_e  state_q, state_d;

    logic        wr_q, wr_d;
    logic [7:0]  bus_q, bus_d;
    logic [15:0] csr_q, csr_d;
    logic [31:0] wd_q, wd_d;
    logic        bad_q, bad_d;
    logic [7:0]  rd_cnt_q, rd_cnt_d;

    logic        rdy_q, rdy_d;
    logic        rsp_vd_q, rsp_vd_d;
    logic [31:0] rsp_rd_q, rsp_rd_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] m_wd_q, m_wd_d;
    logic [31:0] m_adrs_q, m_adrs_d;
    logic        m_wcke_q, m_wcke_d;

    logic        tmr_clr;
    logic        vd_hit;
    logic        vd_timeout;

    usi_master_seq_vd_timer #(
        .pBusNum  (pBusWidth + 1),
        .pTimeout (pTimeout)
    ) u_vd_timer (
        .clk_i      (iUsiClk),
        .rst_ni     (iUsiRst),
        .clr_i      (tmr_clr),
        .en_i       (state_q == ST_WAIT_VD),
        .bus_adrs_i (bus_q),
        .vd_i       (bus.iMUsiVd),
        .hit_o      (vd_hit),
        .timeout_o  (vd_timeout)
    );

    always_ff @(posedge iUsiClk or negedge iUsiRst) begin
        if (!iUsiRst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output registers are loaded on the transition into a state, so each
    // output is valid during the cycle the FSM spends in that state.
    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        bus_d     = bus_q;
        csr_d     = csr_q;
        wd_d      = wd_q;
        bad_d     = bad_q;
        rd_cnt_d  = rd_cnt_q;
        rsp_vd_d  = 1'b0;
        rsp_rd_d  = rsp_rd_q;
        rsp_err_d = rsp_err_q;
        m_wd_d    = m_wd_q;
        m_adrs_d  = m_adrs_q;
        m_wcke_d  = 1'b0;
        tmr_clr   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.iReqVd && rdy_q) begin
                    wr_d    = bus.iReqWr;
                    bus_d   = bus.iReqBusAdrs;
                    csr_d   = bus.iReqCsrAdrs;
                    wd_d    = bus.iReqWd;
                    // Decoded here but reported from WAIT_VD, so a bad
                    // address answers 2 cycles after accept.
                    bad_d   = (bus.iReqBusAdrs == 8'd0) ||
                              (bus.iReqBusAdrs > 8'(pBusNum));
                    tmr_clr = 1'b1;
                    state_d = ST_WAIT_VD;
                end
            end

            ST_WAIT_VD: begin
                if (bad_q || (!vd_hit && vd_timeout)) begin
                    state_d   = ST_RESP;
                    rsp_vd_d  = 1'b1;
                    rsp_err_d = 1'b1;
                    rsp_rd_d  = USI_ERR_DATA;
                    m_adrs_d  = {USI_CMD_IDLE, m_adrs_q[29:0]};
                end else if (vd_hit) begin
                    state_d  = ST_ISSUE;
                    m_wcke_d = 1'b1;
                    m_adrs_d = usi_mk_adrs(wr_q ? USI_CMD_WR : USI_CMD_RD, bus_q, csr_q);
                    m_wd_d   = wr_q ? wd_q : 32'd0;
                end
            end

            ST_ISSUE: begin
                if (wr_q) begin
                    state_d   = ST_RESP;
                    rsp_vd_d  = 1'b1;
                    rsp_err_d = 1'b0;
                    rsp_rd_d  = 32'd0;
                    m_adrs_d  = {USI_CMD_IDLE, m_adrs_q[29:0]};
                end else begin
                    state_d  = ST_RD_WAIT;
                    rd_cnt_d = 8'd1;
                end
            end

            // Address stays on the bus: the bus read mux selects on it.
            ST_RD_WAIT: begin
                if (rd_cnt_q == RD_LAST) begin
                    state_d   = ST_RESP;
                    rsp_vd_d  = 1'b1;
                    rsp_err_d = 1'b0;
                    rsp_rd_d  = bus.iMUsiRd;
                    m_adrs_d  = {USI_CMD_IDLE, m_adrs_q[29:0]};
                end else begin
                    rd_cnt_d = rd_cnt_q + 8'd1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rdy_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge iUsiClk or negedge iUsiRst) begin
        if (!iUsiRst) begin
            wr_q      <= 1'b0;
            bus_q     <= '0;
            csr_q     <= '0;
            wd_q      <= '0;
            bad_q     <= 1'b0;
            rd_cnt_q  <= '0;
            rdy_q     <= 1'b0;
            rsp_vd_q  <= 1'b0;
            rsp_rd_q  <= '0;
            rsp_err_q <= 1'b0;
            m_wd_q    <= '0;
            m_adrs_q  <= '0;
            m_wcke_q  <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            bus_q     <= bus_d;
            csr_q     <= csr_d;
            wd_q      <= wd_d;
            bad_q     <= bad_d;
            rd_cnt_q  <= rd_cnt_d;
            rdy_q     <= rdy_d;
            rsp_vd_q  <= rsp_vd_d;
            rsp_rd_q  <= rsp_rd_d;
            rsp_err_q <= rsp_err_d;
            m_wd_q    <= m_wd_d;
            m_adrs_q  <= m_adrs_d;
            m_wcke_q  <= m_wcke_d;
        end
    end

    assign bus.oReqRdy   = rdy_q;
    assign bus.oRspVd    = rsp_vd_q;
    assign bus.oRspRd    = rsp_rd_q;
    assign bus.oRspErr   = rsp_err_q;
    assign bus.oMUsiWd   = m_wd_q;
    assign bus.oMUsiAdrs = m_adrs_q;
    assign bus.oMUsiWCke = m_wcke_q;

endmodule
